arm_multicycle_controller: RTL and testbench

FSM control unit that sequences a shared-memory ARM multi-cycle datapath. It replaces the single-cycle Decoder for the multi-cycle computer variant. Each cycle it decodes the instruction register fields and issues datapath enables and mux selects. It also owns the NZCV flag register and conditional-execution logic.

---
 rtl/arm_mc_pkg.sv | 38 +++
 rtl/arm_cond_unit.sv | 60 ++++++
 rtl/arm_multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the ARM multi-cycle controller.
// Optional BL support is enabled with the ARM_MC_BL_EN macro, which adds the BLINK state.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
`ifdef ARM_MC_BL_EN
    , BLINK
`endif
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_CMP   = 4'b1010;
  localparam logic [3:0] FLAGS_RST = 4'b0000;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010, COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100, COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110, COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000, COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010, COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100, COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register with S/CMP update enable and condition evaluation.
// condex is combinational from the stored flags; condex_q is captured in DECODE.
module arm_cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_decode,
  input  logic       i_exec,
  input  logic       i_s_bit,
  input  logic [3:0] i_alu_op,
  output logic       o_condex
);

  logic [3:0] r_flags;
  logic       r_condex_q;
  logic       w_n, w_z, w_c, w_v;
  logic       w_flag_we;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    o_condex = 1'b0;
    case (i_cond)
      COND_EQ: o_condex = w_z;
      COND_NE: o_condex = ~w_z;
      COND_CS: o_condex = w_c;
      COND_CC: o_condex = ~w_c;
      COND_MI: o_condex = w_n;
      COND_PL: o_condex = ~w_n;
      COND_VS: o_condex = w_v;
      COND_VC: o_condex = ~w_v;
      COND_HI: o_condex = w_c & ~w_z;
      COND_LS: o_condex = ~w_c | w_z;
      COND_GE: o_condex = (w_n == w_v);
      COND_LT: o_condex = (w_n != w_v);
      COND_GT: o_condex = ~w_z & (w_n == w_v);
      COND_LE: o_condex = w_z | (w_n != w_v);
      COND_AL: o_condex = 1'b1;
      default: o_condex = 1'b0;
    endcase
  end

  // CMP exists only to set flags, so it updates them even without S.
  assign w_flag_we = i_exec & r_condex_q & (i_s_bit | (i_alu_op == ALU_CMP));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags    <= FLAGS_RST;
      r_condex_q <= 1'b0;
    end else begin
      if (i_decode)  r_condex_q <= o_condex;
      if (w_flag_we) r_flags    <= i_alu_flags;
    end
  end

endmodule

// File: rtl/arm_multicycle_controller.sv
// FSM control unit for the shared-memory ARM multi-cycle datapath.
// Define ARM_MC_BL_EN to add BL support (BLINK state and LinkReg output).
module arm_multicycle_controller
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl
`ifdef ARM_MC_BL_EN
  ,
  output logic       LinkReg
`endif
);

  state_t r_state, w_next;
  logic   w_condex, w_rd_pc, w_is_cmp;
  logic   w_pcwrite, w_irwrite, w_regwrite, w_memwrite;

  assign w_rd_pc  = (Rd == 4'd15);
  assign w_is_cmp = (Funct[4:1] == ALU_CMP);

  arm_cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (Cond),
    .i_alu_flags (ALUFlags),
    .i_decode    (r_state == DECODE),
    .i_exec      ((r_state == EXECR) || (r_state == EXECI)),
    .i_s_bit     (Funct[0]),
    .i_alu_op    (Funct[4:1]),
    .o_condex    (w_condex)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next     = FETCH;
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
`ifdef ARM_MC_BL_EN
    LinkReg    = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        w_next    = DECODE;
      end
      DECODE: begin
        // PC already holds PC+4, so this sum is the PC+8 seen as R15.
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (w_condex) begin
          case (Op)
            OP_MEM: w_next = MEMADR;
            OP_DP:  w_next = Funct[5] ? EXECI : EXECR;
`ifdef ARM_MC_BL_EN
            OP_BR:  w_next = Funct[4] ? BLINK : BRANCH;
`else
            OP_BR:  w_next = BRANCH;
`endif
            default: w_next = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        w_next  = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        AdrSrc     = 1'b1;
        ResultSrc  = RES_DATA;
        w_pcwrite  = w_rd_pc;
        w_regwrite = ~w_rd_pc;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (r_state == EXECI) ? SRCB_IMM : SRCB_REG;
        ALUControl = Funct[4:1];
        w_next     = ALUWB;
      end
      ALUWB: begin
        w_pcwrite  = ~w_is_cmp & w_rd_pc;
        w_regwrite = ~w_is_cmp & ~w_rd_pc;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        w_pcwrite = 1'b1;
      end
`ifdef ARM_MC_BL_EN
      BLINK: begin
        ResultSrc  = RES_ALU;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_SUB;
        w_regwrite = 1'b1;
        LinkReg    = 1'b1;
        w_next     = BRANCH;
      end
`endif
      default: w_next = FETCH;
    endcase
  end

  // Enables are gated by reset so an aborted instruction leaves no partial write.
  assign PCWrite  = w_pcwrite  & ~reset;
  assign IRWrite  = w_irwrite  & ~reset;
  assign RegWrite = w_regwrite & ~reset;
  assign MemWrite = w_memwrite & ~reset;

  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_BR, Op == OP_MEM};

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench for arm_multicycle_controller: per-cycle expected control words
// are queued when an instruction is driven and compared at each falling edge.
module tb_arm_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'b1110;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic [3:0] Rd = 4'd0;
  logic [3:0] ALUFlags = 4'b0000;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl;
`ifdef ARM_MC_BL_EN
  logic       LinkReg;
`endif

  arm_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
`ifdef ARM_MC_BL_EN
    ,
    .LinkReg    (LinkReg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] val;
    logic [17:0] mask;
    string       tag;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] model_flags = 4'b0000;

  // Control word: {PCW,IRW,RW,MW, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc}
  function automatic logic [17:0] observed();
    return {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
            ResultSrc, ALUControl, ImmSrc, RegSrc};
  endfunction

  // care = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}; enables and ImmSrc/RegSrc always checked
  task automatic push(input string tag, input logic [3:0] en, input logic adr, input logic asa,
                      input logic [1:0] asb, input logic [1:0] rs, input logic [3:0] alu,
                      input logic [4:0] care);
    exp_t e;
    e.val  = {en, adr, asa, asb, rs, alu, Op, (Op == 2'b10), (Op == 2'b01)};
    e.mask = {4'hF, care[4], care[3], {2{care[2]}}, {2{care[1]}}, {4{care[0]}}, 4'hF};
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t        e;
    logic [17:0] o;
    @(negedge clk);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      o = observed();
      if (((o ^ e.val) & e.mask) !== 18'd0) begin
        n_bad++;
        $display("FAIL %s @%0t: got %b required %b (mask %b)", e.tag, $time, o, e.val, e.mask);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
  endtask

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  task automatic set_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] af);
    Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
  endtask

  task automatic exp_fetch();  push("fetch",  4'b1100, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0100, 5'b11111); endtask
  task automatic exp_decode(); push("decode", 4'b0000, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0100, 5'b01101); endtask

  task automatic do_dp(input logic [3:0] c, input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
    logic pass, cmp;
    set_instr(c, 2'b00, f, rd, af);
    pass = cond_pass(c, model_flags);
    cmp  = (f[4:1] == 4'b1010);
    exp_fetch();
    exp_decode();
    if (pass) begin
      push("exec", 4'b0000, 1'b0, 1'b0, f[5] ? 2'b01 : 2'b00, 2'b00, f[4:1], 5'b01101);
      push("aluwb", {!cmp && rd == 4'd15, 1'b0, !cmp && rd != 4'd15, 1'b0},
           1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 5'b00010);
      if (f[0] || cmp) model_flags = af;
    end
    drain();
  endtask

  task automatic do_mem(input logic [3:0] c, input logic load, input logic [3:0] rd);
    set_instr(c, 2'b01, load ? 6'b011001 : 6'b011000, rd, 4'b0000);
    exp_fetch();
    exp_decode();
    if (cond_pass(c, model_flags)) begin
      push("memadr", 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0100, 5'b01101);
      if (load) begin
        push("memrd", 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 5'b10000);
        push("memwb", {rd == 4'd15, 1'b0, rd != 4'd15, 1'b0}, 1'b1, 1'b0, 2'b00, 2'b01, 4'b0000, 5'b10010);
      end else begin
        push("memwr", 4'b0001, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 5'b10000);
      end
    end
    drain();
  endtask

  task automatic do_branch(input logic [3:0] c, input logic [5:0] f);
    set_instr(c, 2'b10, f, 4'd0, 4'b0000);
    exp_fetch();
    exp_decode();
    if (cond_pass(c, model_flags)) begin
`ifdef ARM_MC_BL_EN
      if (f[4]) push("blink", 4'b0010, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0010, 5'b01111);
`endif
      push("branch", 4'b1000, 1'b0, 1'b0, 2'b01, 2'b10, 4'b0100, 5'b01111);
    end
    drain();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    push("in_reset", 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 5'b00000);
    step();
    reset = 1'b0;
    model_flags = 4'b0000;
    do_branch(4'b0000, 6'b100000);
    do_branch(4'b0001, 6'b100000);
  endtask

  task automatic test_cond_table(input logic [3:0] af);
    do_dp(4'b1110, 6'b000101, 4'd1, af);
    for (int c = 0; c < 16; c++) do_branch(c[3:0], 6'b100000);
  endtask

  task automatic test_ldr();
    do_mem(4'b1110, 1'b1, 4'd3);
    do_mem(4'b1110, 1'b1, 4'd15);
  endtask

  task automatic test_subs_beq();
    do_dp(4'b1110, 6'b000101, 4'd2, 4'b0100);
    do_branch(4'b0000, 6'b100000);
  endtask

  task automatic test_cond_fail();
    do_branch(4'b0001, 6'b100000);
    do_mem(4'b0001, 1'b0, 4'd4);
    do_dp(4'b0001, 6'b000101, 4'd2, 4'b1000);
    do_branch(4'b0000, 6'b100000);
  endtask

  task automatic test_cmp_add_pc();
    do_dp(4'b1110, 6'b010101, 4'd0, 4'b1000);
    do_branch(4'b0100, 6'b100000);
    do_dp(4'b1110, 6'b010100, 4'd0, 4'b0010);
    do_branch(4'b0010, 6'b100000);
    do_dp(4'b1110, 6'b001000, 4'd15, 4'b0100);
    do_branch(4'b0000, 6'b100000);
    do_dp(4'b1110, 6'b101000, 4'd4, 4'b0000);
  endtask

  task automatic test_misc();
    set_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
    exp_fetch();
    exp_decode();
    drain();
    do_branch(4'b1110, 6'b110000);
    do_mem(4'b1110, 1'b0, 4'd5);
  endtask

  task automatic test_reset_abort();
    do_dp(4'b1110, 6'b000101, 4'd1, 4'b0100);
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd5, 4'b0000);
    exp_fetch();
    exp_decode();
    step();
    step();
    reset = 1'b1;
    push("memadr_reset", 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 5'b00000);
    step();
    reset = 1'b0;
    model_flags = 4'b0000;
    do_branch(4'b0000, 6'b100000);
    do_branch(4'b1110, 6'b100000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cond_table(4'b0000);
    test_cond_table(4'b0110);
    test_cond_table(4'b1001);
    test_cond_table(4'b1010);
    test_ldr();
    test_subs_beq();
    test_cond_fail();
    test_cmp_add_pc();
    test_misc();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
